// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter and its source FIFOs.
package regfile_wb_arbiter_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  // Writeback source indices
  localparam int SRC_ALU  = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_LINK = 2;

  // r0 is hard-wired zero: writes to it are dropped at the FIFO input
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // Round-robin successor with wrap at n
  function automatic int rr_succ(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// Per-source writeback FIFO. Exposes every slot and its valid bit so the
// parent can compare pending destinations against decode read addresses.
module regfile_wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [ADDR_W-1:0]             push_addr_i,
  input  logic [DATA_W-1:0]             push_data_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [ADDR_W-1:0]             head_addr_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr_o,
  output logic [DEPTH-1:0]              ent_vld_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [PTR_W-1:0]             rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign ent_addr_o  = addr_q;
  assign ent_vld_o   = vld_q;

  // Next-state slot valid bits and occupancy; push and pop never hit the same slot
  always_comb begin
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (do_push) vld_d[wr_ptr_q] = 1'b1;
    if (do_pop)  vld_d[rd_ptr_q] = 1'b0;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and occupancy; reset discards all buffered entries
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      data_q   <= '0;
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      if (do_push) begin
        addr_q[wr_ptr_q] <= push_addr_i;
        data_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q         <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: per-source FIFOs drained round-robin into a
// registered write port, plus pending-write hazard flags and a sticky WAW error.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      w_en,
  output logic [ADDR_W-1:0]         w_address_d_5,
  output logic [DATA_W-1:0]         w_data_dval_32,
  input  logic [ADDR_W-1:0]         rd_addr_s1,
  input  logic [ADDR_W-1:0]         rd_addr_s2,
  output logic                      hazard_s1,
  output logic                      hazard_s2,
  output logic                      err_waw
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                               push, pop, full, empty;
  logic [NUM_REQ-1:0][ADDR_W-1:0]                   head_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0]                   head_data;
  logic [NUM_REQ-1:0][FIFO_DEPTH-1:0][ADDR_W-1:0]   ent_addr;
  logic [NUM_REQ-1:0][FIFO_DEPTH-1:0]               ent_vld;

  logic [RR_W-1:0]   rr_q, rr_d, grant_idx;
  logic              grant_vld;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              err_waw_q, err_waw_d;
  logic              waw_hit, haz1_raw, haz2_raw;

  // One FIFO per source; r0 writes are handshaken but never enqueued
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_src
    assign req_ready[i] = !full[i];
    assign push[i]      = req_valid[i] && !full[i] &&
                          (req_addr[i*ADDR_W +: ADDR_W] != REG_ZERO);
    assign pop[i]       = grant_vld && (grant_idx == RR_W'(i));

    regfile_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock       (clock),
      .reset_n     (reset_n),
      .push_i      (push[i]),
      .pop_i       (pop[i]),
      .push_addr_i (req_addr[i*ADDR_W +: ADDR_W]),
      .push_data_i (req_data[i*DATA_W +: DATA_W]),
      .full_o      (full[i]),
      .empty_o     (empty[i]),
      .head_addr_o (head_addr[i]),
      .head_data_o (head_data[i]),
      .ent_addr_o  (ent_addr[i]),
      .ent_vld_o   (ent_vld[i])
    );
  end

  // Round-robin pick: first non-empty head scanning upward from rr_q
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && !empty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = RR_W'(idx);
      end
    end
  end

  // Next-state for pointer and write-port drive
  always_comb begin
    rr_d     = rr_q;
    w_en_d   = grant_vld;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (grant_vld) begin
      rr_d     = RR_W'(rr_succ(int'(grant_idx), NUM_REQ));
      w_addr_d = head_addr[grant_idx];
      w_data_d = head_data[grant_idx];
    end
  end

  // Accepted nonzero address already pending in another source's FIFO
  always_comb begin
    waw_hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      for (int j = 0; j < NUM_REQ; j++)
        for (int d = 0; d < FIFO_DEPTH; d++)
          if (push[i] && (i != j) && ent_vld[j][d] &&
              (ent_addr[j][d] == req_addr[i*ADDR_W +: ADDR_W]))
            waw_hit = 1'b1;
    err_waw_d = err_waw_q || waw_hit;
  end

  // Pending-write hazards: any buffered entry or the live write-port value
  always_comb begin
    haz1_raw = w_en_q && (w_addr_q == rd_addr_s1);
    haz2_raw = w_en_q && (w_addr_q == rd_addr_s2);
    for (int i = 0; i < NUM_REQ; i++)
      for (int d = 0; d < FIFO_DEPTH; d++) begin
        if (ent_vld[i][d] && (ent_addr[i][d] == rd_addr_s1)) haz1_raw = 1'b1;
        if (ent_vld[i][d] && (ent_addr[i][d] == rd_addr_s2)) haz2_raw = 1'b1;
      end
  end

  assign hazard_s1 = haz1_raw && (rd_addr_s1 != REG_ZERO);
  assign hazard_s2 = haz2_raw && (rd_addr_s2 != REG_ZERO);

  // Registered write port, RR pointer and sticky error
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q      <= '0;
      w_en_q    <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      err_waw_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      w_en_q    <= w_en_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      err_waw_q <= err_waw_d;
    end
  end

  assign w_en           = w_en_q;
  assign w_address_d_5  = w_addr_q;
  assign w_data_dval_32 = w_data_q;
  assign err_waw        = err_waw_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: stimulus pushes expected writes into a scoreboard queue,
// a negedge monitor pops and compares every write-port pulse.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        w_en;
  logic [4:0]  w_address_d_5;
  logic [31:0] w_data_dval_32;
  logic [4:0]  rd_addr_s1, rd_addr_s2;
  logic        hazard_s1, hazard_s2, err_waw;

  int n_pass = 0;
  int n_total = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  regfile_wb_arbiter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .w_en           (w_en),
    .w_address_d_5  (w_address_d_5),
    .w_data_dval_32 (w_data_dval_32),
    .rd_addr_s1     (rd_addr_s1),
    .rd_addr_s2     (rd_addr_s2),
    .hazard_s1      (hazard_s1),
    .hazard_s2      (hazard_s2),
    .err_waw        (err_waw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int s, input logic [4:0] a, input logic [31:0] d);
    req_valid[s]          = 1'b1;
    req_addr[s*5 +: 5]    = a;
    req_data[s*32 +: 32]  = d;
  endtask

  task automatic clr_req();
    req_valid = '0;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Scoreboard monitor: every write-port pulse must match the queue head
  always @(negedge clock) begin
    if (reset_n && w_en) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL wb_write unexpected addr=%0d data=%h", w_address_d_5, w_data_dval_32);
      end else begin
        mon_e = exp_q.pop_front();
        if (w_address_d_5 === mon_e[36:32] && w_data_dval_32 === mon_e[31:0]) n_pass++;
        else $display("FAIL wb_write got addr=%0d data=%h exp addr=%0d data=%h",
                      w_address_d_5, w_data_dval_32, mon_e[36:32], mon_e[31:0]);
      end
    end
  end

  initial begin
    int n;
    reset_n    = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
    rd_addr_s1 = '0;
    rd_addr_s2 = '0;

    // Reset: valids driven while held in reset
    set_req(0, 5'd6, 32'h1); set_req(1, 5'd6, 32'h2); set_req(2, 5'd6, 32'h3);
    repeat (3) cycle();
    check("rst_wen", 32'(w_en), 32'd0);
    check("rst_addr", 32'(w_address_d_5), 32'd0);
    check("rst_data", w_data_dval_32, 32'd0);
    check("rst_err", 32'(err_waw), 32'd0);
    clr_req();
    reset_n = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'h7);
    cycle();

    // Single write with latency and one-cycle pulse
    set_req(0, 5'd5, 32'hDEADBEEF);
    expect_wr(5'd5, 32'hDEADBEEF);
    cycle();
    clr_req();
    check("single_lat_k", 32'(w_en), 32'd0);
    cycle();
    check("single_wen", 32'(w_en), 32'd1);
    cycle();
    check("single_one_cycle", 32'(w_en), 32'd0);
    repeat (3) cycle();

    // Contention with RR=1 -> 2,3,1
    set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
    expect_wr(5'd2, 32'h22); expect_wr(5'd3, 32'h33); expect_wr(5'd1, 32'h11);
    cycle();
    clr_req();
    repeat (6) cycle();

    // Single src2 write leaves RR=0
    set_req(2, 5'd4, 32'h44);
    expect_wr(5'd4, 32'h44);
    cycle();
    clr_req();
    repeat (4) cycle();

    // Contention with RR=0 -> 1,2,3
    set_req(0, 5'd1, 32'hA1); set_req(1, 5'd2, 32'hA2); set_req(2, 5'd3, 32'hA3);
    expect_wr(5'd1, 32'hA1); expect_wr(5'd2, 32'hA2); expect_wr(5'd3, 32'hA3);
    cycle();
    clr_req();
    repeat (6) cycle();

    // Backpressure on src1: fills to 2, third push held one cycle
    expect_wr(5'd10, 32'hB0); expect_wr(5'd11, 32'hB1); expect_wr(5'd12, 32'hB2);
    expect_wr(5'd13, 32'hB3); expect_wr(5'd14, 32'hB4);
    set_req(0, 5'd10, 32'hB0); set_req(1, 5'd11, 32'hB1); set_req(2, 5'd12, 32'hB2);
    cycle();
    clr_req();
    set_req(1, 5'd13, 32'hB3);
    cycle();
    clr_req();
    check("bp_full_ready1", 32'(req_ready[1]), 32'd0);
    check("bp_ready0", 32'(req_ready[0]), 32'd1);
    set_req(1, 5'd14, 32'hB4);
    n = 0;
    while (!req_ready[1] && n < 20) begin
      cycle();
      n++;
    end
    check("bp_held_cycles", 32'(n), 32'd1);
    cycle();
    clr_req();
    repeat (6) cycle();

    // r0 drop and hazards
    rd_addr_s1 = 5'd7;
    rd_addr_s2 = 5'd0;
    set_req(0, 5'd0, 32'hBAD);
    cycle();
    clr_req();
    repeat (3) cycle();
    check("haz_r0", 32'(hazard_s1), 32'd0);
    set_req(0, 5'd7, 32'h77);
    expect_wr(5'd7, 32'h77);
    #1;
    check("haz_pre", 32'(hazard_s1), 32'd0);
    cycle();
    clr_req();
    check("haz_fifo", 32'(hazard_s1), 32'd1);
    check("haz_s2_zero_a", 32'(hazard_s2), 32'd0);
    cycle();
    check("haz_outreg", 32'(hazard_s1), 32'd1);
    check("haz_outreg_wen", 32'(w_en), 32'd1);
    cycle();
    check("haz_clear", 32'(hazard_s1), 32'd0);
    check("haz_s2_zero_b", 32'(hazard_s2), 32'd0);
    rd_addr_s2 = 5'd8;
    set_req(1, 5'd8, 32'h88);
    expect_wr(5'd8, 32'h88);
    cycle();
    clr_req();
    check("haz2_fifo", 32'(hazard_s2), 32'd1);
    check("haz1_other", 32'(hazard_s1), 32'd0);
    repeat (4) cycle();
    rd_addr_s1 = '0;
    rd_addr_s2 = '0;

    // WAW across src0 and src2
    check("waw_pre", 32'(err_waw), 32'd0);
    set_req(0, 5'd9, 32'h900);
    expect_wr(5'd9, 32'h900);
    cycle();
    clr_req();
    set_req(2, 5'd9, 32'h902);
    expect_wr(5'd9, 32'h902);
    cycle();
    clr_req();
    check("waw_set", 32'(err_waw), 32'd1);
    repeat (5) cycle();
    check("waw_sticky", 32'(err_waw), 32'd1);

    // Reset mid-operation with entries buffered: nothing emitted afterwards
    set_req(0, 5'd20, 32'hC0); set_req(1, 5'd21, 32'hC1); set_req(2, 5'd22, 32'hC2);
    cycle();
    set_req(0, 5'd23, 32'hC3); set_req(1, 5'd24, 32'hC4); set_req(2, 5'd25, 32'hC5);
    cycle();
    clr_req();
    reset_n = 1'b0;
    repeat (2) cycle();
    reset_n = 1'b1;
    #1;
    check("midrst_err", 32'(err_waw), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'h7);
    repeat (10) cycle();
    check("midrst_wen", 32'(w_en), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
